// File: rtl/wb2apb_bridge.sv
// rtl/wb2apb_bridge.sv - Wishbone classic slave to APB4 master bridge
//
// Purpose:
//   Lets a Wishbone classic initiator reach APB peripherals. A registered
//   IDLE/SETUP/ACCESS/RESP state machine produces legal APB phases and returns
//   exactly one ack or err pulse per accepted WB cycle. An optional PREADY
//   timeout keeps a hung peripheral from stalling the bus.
//
// Ports:
//   PCLK, PRESETn          single clock, synchronous active-low reset
//   wb_cyc_i, wb_stb_i     WB request qualifiers
//   wb_we_i, wb_adr_i      WB direction and address
//   wb_dat_i, wb_sel_i     WB write data and byte selects
//   wb_dat_o               WB read data, valid with wb_ack_o
//   wb_ack_o, wb_err_o     WB completion pulses (one cycle each)
//   PADDR, PPROT, PSEL     APB address, protection (fixed 0), select
//   PENABLE, PWRITE        APB enable and direction
//   PWDATA, PSTRB          APB write data and write strobes
//   PREADY, PRDATA         APB ready and read data
//   PSLVERR                APB slave error

module wb2apb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [2:0]              PPROT,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);

  localparam int SW = DATA_WIDTH / 8;
  // With TIMEOUT=0 the counter is unused by the timeout logic, but keep one bit
  // so the vector stays legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d, dat_d;
  logic [SW-1:0]         pstrb_d;
  logic                  pwrite_d, psel_d, penable_d, ack_d, err_d;
  logic                  timeout_hit;

  assign PPROT = 3'b000;

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Next-state and next-output decode; every output is then registered.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    paddr_d   = PADDR;
    pwdata_d  = PWDATA;
    pstrb_d   = PSTRB;
    pwrite_d  = PWRITE;
    psel_d    = PSEL;
    penable_d = PENABLE;
    dat_d     = wb_dat_o;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          paddr_d   = wb_adr_i;
          pwdata_d  = wb_dat_i;
          pwrite_d  = wb_we_i;
          pstrb_d   = wb_we_i ? wb_sel_i : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          if (!PWRITE) begin
            dat_d = PRDATA;
          end
          // An initiator that abandoned the cycle gets no completion pulse.
          ack_d     = wb_cyc_i & ~PSLVERR;
          err_d     = wb_cyc_i &  PSLVERR;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = ST_RESP;
        end else if (timeout_hit) begin
          err_d     = wb_cyc_i;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = ST_RESP;
        end else if (cnt != CNT_MAX) begin
          cnt_d = cnt + 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      PADDR    <= '0;
      PWDATA   <= '0;
      PSTRB    <= '0;
      PWRITE   <= 1'b0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      PADDR    <= paddr_d;
      PWDATA   <= pwdata_d;
      PSTRB    <= pstrb_d;
      PWRITE   <= pwrite_d;
      PSEL     <= psel_d;
      PENABLE  <= penable_d;
      wb_dat_o <= dat_d;
      wb_ack_o <= ack_d;
      wb_err_o <= err_d;
    end
  end

endmodule

// File: tb/tb_wb2apb_bridge.sv
// tb/tb_wb2apb_bridge.sv - directed testbench for wb2apb_bridge

module tb_wb2apb_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] PADDR;
  logic [2:0]  PPROT;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int errors = 0;
  int checks = 0;

  wb2apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic wb_request(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
  endtask

  task automatic wb_drop();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  // Full transfer starting in an IDLE cycle; returns in the IDLE cycle after RESP.
  task automatic do_xfer(input string name, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input int waits,
                         input logic [31:0] rdata, input logic slverr,
                         input logic [3:0] exp_strb, input logic [31:0] exp_dat);
    wb_request(we, adr, dat, sel);
    PREADY = 1'b0;
    step();
    checks++;
    if ({PSEL, PENABLE} !== 2'b10) begin
      errors++; $display("FAIL %s setup phase: psel/penable=%b required 10", name, {PSEL, PENABLE});
    end
    checks++;
    if ({PADDR, PWRITE, PSTRB} !== {adr, we, exp_strb}) begin
      errors++; $display("FAIL %s setup ctrl: addr=%h write=%b strb=%h required %h %b %h",
                         name, PADDR, PWRITE, PSTRB, adr, we, exp_strb);
    end
    if (we) begin
      checks++;
      if (PWDATA !== dat) begin
        errors++; $display("FAIL %s pwdata: %h required %h", name, PWDATA, dat);
      end
    end
    step();
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if ({PSEL, PENABLE, wb_ack_o, wb_err_o} !== 4'b1100 || PADDR !== adr || PSTRB !== exp_strb) begin
        errors++; $display("FAIL %s access cycle %0d: psel/pen/ack/err=%b addr=%h strb=%h required 1100 %h %h",
                           name, i, {PSEL, PENABLE, wb_ack_o, wb_err_o}, PADDR, PSTRB, adr, exp_strb);
      end
      if (i == waits) begin
        PREADY = 1'b1; PRDATA = rdata; PSLVERR = slverr;
      end
      step();
    end
    checks++;
    if ({wb_ack_o, wb_err_o, PSEL, PENABLE} !== {~slverr, slverr, 2'b00}) begin
      errors++; $display("FAIL %s resp: ack/err/psel/pen=%b required %b", name,
                         {wb_ack_o, wb_err_o, PSEL, PENABLE}, {~slverr, slverr, 2'b00});
    end
    checks++;
    if (wb_dat_o !== exp_dat) begin
      errors++; $display("FAIL %s wb_dat_o: %h required %h", name, wb_dat_o, exp_dat);
    end
    wb_drop();
    step();
    checks++;
    if ({wb_ack_o, wb_err_o, PSEL} !== 3'b000) begin
      errors++; $display("FAIL %s pulse width: ack/err/psel=%b required 000", name, {wb_ack_o, wb_err_o, PSEL});
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    wb_drop();
    wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; PRDATA = '0;
    step(); step();
    checks++;
    if ({PSEL, PENABLE, PWRITE, wb_ack_o, wb_err_o} !== 5'b0 || PPROT !== 3'b000) begin
      errors++; $display("FAIL reset ctrl: %b pprot=%b required 00000 000",
                         {PSEL, PENABLE, PWRITE, wb_ack_o, wb_err_o}, PPROT);
    end
    checks++;
    if ({PADDR, PWDATA, PSTRB, wb_dat_o} !== 100'h0) begin
      errors++; $display("FAIL reset data: addr=%h wdata=%h strb=%h rdata=%h required all 0",
                         PADDR, PWDATA, PSTRB, wb_dat_o);
    end
    PRESETn = 1'b1;
    step();
  endtask

  task automatic test_write();
    do_xfer("write0", 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 32'h0, 1'b0, 4'hF, 32'h0);
  endtask

  task automatic test_read_wait();
    do_xfer("read3w", 1'b0, 32'h24, 32'h1111_2222, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'hDEAD_BEEF);
  endtask

  task automatic test_slverr();
    // Write keeps the last read data on wb_dat_o.
    do_xfer("slverr", 1'b1, 32'h30, 32'h0000_00FF, 4'h3, 1, 32'h5555_5555, 1'b1, 4'h3, 32'hDEAD_BEEF);
  endtask

  task automatic test_timeout();
    wb_request(1'b1, 32'h40, 32'h1234_5678, 4'hF);
    PREADY = 1'b0;
    step();
    step();
    for (int i = 1; i < 16; i++) step();
    checks++;
    if ({PSEL, PENABLE, wb_err_o} !== 3'b110) begin
      errors++; $display("FAIL timeout access16: psel/pen/err=%b required 110", {PSEL, PENABLE, wb_err_o});
    end
    step();
    checks++;
    if ({PSEL, PENABLE, wb_ack_o, wb_err_o} !== 4'b0001) begin
      errors++; $display("FAIL timeout resp: psel/pen/ack/err=%b required 0001", {PSEL, PENABLE, wb_ack_o, wb_err_o});
    end
    wb_drop();
    step();
    checks++;
    if ({wb_ack_o, wb_err_o, PSEL} !== 3'b000) begin
      errors++; $display("FAIL timeout after: ack/err/psel=%b required 000", {wb_ack_o, wb_err_o, PSEL});
    end
  endtask

  task automatic test_reset_mid();
    wb_request(1'b1, 32'h50, 32'hCAFE_0000, 4'hF);
    PREADY = 1'b0;
    step();
    step();
    PRESETn = 1'b0;
    wb_drop();
    step();
    checks++;
    if ({PSEL, PENABLE, wb_ack_o, wb_err_o} !== 4'b0000 || PADDR !== 32'h0) begin
      errors++; $display("FAIL reset mid: psel/pen/ack/err=%b addr=%h required 0000 0",
                         {PSEL, PENABLE, wb_ack_o, wb_err_o}, PADDR);
    end
    PRESETn = 1'b1;
    step();
    do_xfer("post_rst", 1'b1, 32'h54, 32'h0BAD_F00D, 4'hC, 0, 32'h0, 1'b0, 4'hC, 32'h0);
  endtask

  task automatic test_drop_cyc();
    wb_request(1'b1, 32'h60, 32'h7777_7777, 4'hF);
    PREADY = 1'b0;
    step();
    wb_drop();
    step();
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      errors++; $display("FAIL drop cyc access: psel/pen=%b required 11", {PSEL, PENABLE});
    end
    PREADY = 1'b1;
    step();
    PREADY = 1'b0;
    checks++;
    if ({wb_ack_o, wb_err_o, PSEL, PENABLE} !== 4'b0000) begin
      errors++; $display("FAIL drop cyc resp: ack/err/psel/pen=%b required 0000", {wb_ack_o, wb_err_o, PSEL, PENABLE});
    end
    step();
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    wb_request(1'b1, 32'h70, 32'h0000_0070, 4'hF);
    PREADY = 1'b0;
    step();
    checks++;
    if ({PSEL, PENABLE, PADDR} !== {2'b10, 32'h70}) begin
      errors++; $display("FAIL b2b setup1: psel/pen=%b addr=%h required 10 70", {PSEL, PENABLE}, PADDR);
    end
    step();
    PREADY = 1'b1;
    step();
    PREADY = 1'b0;
    if (wb_ack_o) acks++;
    // Initiator presents its next request while still holding cyc/stb.
    wb_request(1'b1, 32'h74, 32'h0000_0074, 4'h1);
    step();
    checks++;
    if ({PSEL, PENABLE, wb_ack_o} !== 3'b000) begin
      errors++; $display("FAIL b2b idle gap: psel/pen/ack=%b required 000", {PSEL, PENABLE, wb_ack_o});
    end
    step();
    checks++;
    if ({PSEL, PENABLE, PADDR, PSTRB} !== {2'b10, 32'h74, 4'h1}) begin
      errors++; $display("FAIL b2b setup2: psel/pen=%b addr=%h strb=%h required 10 74 1",
                         {PSEL, PENABLE}, PADDR, PSTRB);
    end
    step();
    PREADY = 1'b1;
    step();
    if (wb_ack_o) acks++;
    wb_drop();
    step();
    checks++;
    if (acks !== 2) begin
      errors++; $display("FAIL b2b ack count: %0d required 2", acks);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_drop_cyc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
